serial_adder: RTL and testbench

- Multi-cycle bit-serial adder/accumulator stage for the CPU datapath.
- Accepts two WIDTH-bit operands and a carry-in via a start/done handshake.
- Adds LSB-first, one bit per clock, through a single one-bit full-adder cell. Result, carry-out and signed overflow are registered and held for downstream ALU/writeback logic.
- Trades WIDTH+1 cycles of latency for one adder cell in place of a ripple chain.

---
 rtl/serial_adder_pkg.sv | 13 +
 rtl/serial_adder_if.sv | 21 ++
 rtl/serial_adder_fulladder.sv | 11 +
 rtl/serial_adder.sv | 73 +++++++
 tb/tb_serial_adder.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: state encoding and default datapath width shared by the
// serial adder slice.
package serial_adder_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam int DATA_W = 8;
    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        DONE  = ST_DONE
    } state_t;
endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: start/done handshake plus operand and result bus of the
// bit-serial adder.
interface serial_adder_if import serial_adder_pkg::*; #(parameter int WIDTH = DATA_W);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;
    modport master (
        output start, a, b, carry_in,
        input  busy, done, sum, carry_out, overflow
    );
    modport slave (
        input  start, a, b, carry_in,
        output busy, done, sum, carry_out, overflow
    );
endinterface

// File: rtl/serial_adder_fulladder.sv
// fulladder: one-bit full-adder cell, the only arithmetic of the serial adder.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic carry_out,
    output logic sum
);
    assign sum       = a ^ b ^ carry_in;
    assign carry_out = (a & b) | (carry_in & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder; one full-adder cell, WIDTH+1 edges
// from accepted start to a registered sum/carry/overflow and a one-cycle done.
module serial_adder import serial_adder_pkg::*; #(
    parameter int WIDTH = DATA_W
) (
    input logic           clk,
    input logic           rst,
    serial_adder_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);
    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic             cff;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             fa_sum;
    logic             fa_cout;
    fulladder u_fa (
        .a        (a_sr[0]),
        .b        (b_sr[0]),
        .carry_in (cff),
        .carry_out(fa_cout),
        .sum      (fa_sum)
    );
    assign bus.busy      = (state == SHIFT) || (state == DONE);
    assign bus.done      = state == DONE;
    assign bus.sum       = sum_q;
    assign bus.carry_out = cout_q;
    assign bus.overflow  = ovf_q;
    // Result registers update only on the edge entering DONE, so they hold
    // the previous result throughout the next operation's SHIFT phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            s_sr   <= '0;
            cff    <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    a_sr  <= bus.a;
                    b_sr  <= bus.b;
                    cff   <= bus.carry_in;
                    cnt   <= '0;
                    state <= SHIFT;
                end
                SHIFT: begin
                    s_sr <= {fa_sum, s_sr[WIDTH-1:1]};
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    cff  <= fa_cout;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        sum_q  <= {fa_sum, s_sr[WIDTH-1:1]};
                        cout_q <= fa_cout;
                        ovf_q  <= cff ^ fa_cout;
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: vector table, random sweep against a+b+cin, back-to-back
// starts and asynchronous reset mid-operation for the bit-serial adder.
module tb_serial_adder;
    localparam int W = 8;
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    serial_adder_if #(.WIDTH(W)) bus ();
    serial_adder #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask
    // {overflow, carry_out, sum} from plain arithmetic and the sign rule
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        logic [W:0] t;
        logic       ov;
        t  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        ov = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
        return {ov, t};
    endfunction
    function automatic logic [W+1:0] outs();
        return {bus.overflow, bus.carry_out, bus.sum};
    endfunction
    always @(negedge clk)
        if (!rst && $isunknown({bus.busy, bus.done, bus.sum, bus.carry_out, bus.overflow})) begin
            bad++;
            $display("FAIL xcheck: outputs unknown at %0t", $time);
        end
    // Caller is #1 after a rising edge with the DUT idle.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         output logic [W+1:0] res);
        logic [W+1:0] prev;
        bit           stable;
        int           n;
        prev   = outs();
        stable = 1;
        n      = 0;
        bus.a = a;
        bus.b = b;
        bus.carry_in = cin;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a = ~a;
        bus.b = W'($urandom);
        bus.carry_in = ~cin;
        chk("busy_after_accept", {31'd0, bus.busy}, 32'd1);
        while (!bus.done && n < 20) begin
            if (outs() !== prev) stable = 0;
            @(posedge clk); #1;
            n++;
        end
        chk("result_hold", {31'd0, stable}, 32'd1);
        chk("latency", n, W);
        res = outs();
        @(posedge clk); #1;
        chk("done_pulse", {30'd0, bus.done, bus.busy}, 32'd0);
    endtask
    initial begin
        vec_t         tbl[8];
        logic [W+1:0] r;
        logic [W-1:0] ca[3];
        logic [W-1:0] cb[3];
        logic         cc[3];
        int           k;
        int           last;
        int           t;
        bit           quiet;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.carry_in = 1'b0;
        tbl = '{
            '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0},
            '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0},
            '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1},
            '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1},
            '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0},
            '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0},
            '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1},
            '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0}
        };
        #12 rst = 1'b0;
        @(posedge clk); #1;
        chk("reset_outs", {21'd0, bus.busy, bus.done, outs()}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            do_op(tbl[i].a, tbl[i].b, tbl[i].cin, r);
            chk($sformatf("vec%0d_sum", i), {24'd0, r[W-1:0]}, {24'd0, tbl[i].s});
            chk($sformatf("vec%0d_cout", i), {31'd0, r[W]}, {31'd0, tbl[i].co});
            chk($sformatf("vec%0d_ovf", i), {31'd0, r[W+1]}, {31'd0, tbl[i].ov});
        end
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rc;
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            do_op(ra, rb, rc, r);
            chk("random", {22'd0, r}, {22'd0, model(ra, rb, rc)});
        end
        // start held high: three back-to-back ops, junk operands during SHIFT
        for (int i = 0; i < 3; i++) begin
            ca[i] = W'($urandom);
            cb[i] = W'($urandom);
            cc[i] = 1'($urandom);
        end
        k = 0;
        last = 0;
        t = 0;
        bus.a = ca[0];
        bus.b = cb[0];
        bus.carry_in = cc[0];
        bus.start = 1'b1;
        while (k < 3 && t < 100) begin
            @(posedge clk); #1;
            t++;
            if (bus.done) begin
                chk("cont_result", {22'd0, outs()}, {22'd0, model(ca[k], cb[k], cc[k])});
                if (k > 0) chk("cont_period", t - last, W + 2);
                last = t;
                k++;
                if (k < 3) begin
                    bus.a = ca[k];
                    bus.b = cb[k];
                    bus.carry_in = cc[k];
                end else bus.start = 1'b0;
            end else if (bus.busy) begin
                bus.a = W'($urandom);
                bus.b = W'($urandom);
                bus.carry_in = 1'($urandom);
            end
        end
        chk("cont_count", k, 3);
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_op(8'h12, 8'h34, 1'b0, r);
        chk("pre_reset", {22'd0, r}, {22'd0, model(8'h12, 8'h34, 1'b0)});
        bus.a = 8'hA5;
        bus.b = 8'h5A;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_reset", {21'd0, bus.busy, bus.done, outs()}, 32'd0);
        #2 rst = 1'b0;
        quiet = 1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.busy || bus.done || outs() !== '0) quiet = 0;
        end
        chk("no_restore", {31'd0, quiet}, 32'd1);
        do_op(8'hC3, 8'h3D, 1'b1, r);
        chk("post_reset", {22'd0, r}, {22'd0, model(8'hC3, 8'h3D, 1'b1)});
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
